// File: rtl/bus_pkg.sv
// Shared definitions for the bus-cycle acknowledge logic:
// region codes, FSM states, default timing constants.
package bus_pkg;

    localparam logic [2:0] REG_NONE = 3'd0;
    localparam logic [2:0] REG_ROM  = 3'd1;
    localparam logic [2:0] REG_RAM  = 3'd2;
    localparam logic [2:0] REG_IO   = 3'd3;
    localparam logic [2:0] REG_DRAM = 3'd4;
    localparam logic [2:0] REG_CAN  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        BERR = 2'd3
    } state_e;

    localparam int DEF_ROM_WAIT = 0;
    localparam int DEF_RAM_WAIT = 1;
    localparam int DEF_IO_WAIT  = 3;
    localparam int DEF_TIMEOUT  = 255;
    localparam int DEF_CNT_W    = 8;

    function automatic logic region_is_internal(input logic [2:0] r);
        return (r == REG_ROM) || (r == REG_RAM) || (r == REG_IO);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable up/down saturating counter for bus-cycle timing.
// Ports: clk, rst_n, load/load_val, en, up; flags zero and term (==TIMEOUT).
module wait_counter #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic             zero,
    output logic             term
);

    localparam logic [CNT_W-1:0] MAX_V  = '1;
    localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign zero = (cnt_q == '0);
    assign term = (cnt_q == TERM_V);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (up) begin
                cnt_d = (cnt_q == MAX_V) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = zero ? cnt_q : cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_dtack_generator.sv
// 68000 bus-cycle timing: DTACK_L with per-region wait states, external
// ack pass-through, BERR_L on unmapped access or timeout. Inputs: Clock,
// Reset_L, bus strobes, decoder selects, slave acks. Outputs: DTACK_L,
// BERR_L, Region_O (all registered).
module bus_dtack_generator
    import bus_pkg::*;
#(
    parameter int ROM_WAIT = DEF_ROM_WAIT,
    parameter int RAM_WAIT = DEF_RAM_WAIT,
    parameter int IO_WAIT  = DEF_IO_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic       Clock,
    input  logic       Reset_L,
    input  logic       AS_L,
    input  logic       UDS_L,
    input  logic       LDS_L,
    input  logic       OnChipRomSelect_H,
    input  logic       OnChipRamSelect_H,
    input  logic       IOSelect_H,
    input  logic       DramSelect_H,
    input  logic       CanBusSelect_H,
    input  logic       DramDtack_L,
    input  logic       CanDtack_L,
    output logic       DTACK_L,
    output logic       BERR_L,
    output logic [2:0] Region_O
);

    localparam logic [CNT_W-1:0] ROM_LD = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_LD = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] IO_LD  = CNT_W'(IO_WAIT);

    state_e     state_q, state_d;
    logic [2:0] region_q, region_d;
    logic       dtack_l_q, dtack_l_d;
    logic       berr_l_q, berr_l_d;

    logic             start;
    logic [2:0]       region_sel;
    logic [CNT_W-1:0] load_val;
    logic             ext_ack;
    logic             cnt_load, cnt_en, cnt_up;
    logic             cnt_zero, cnt_term;

    assign DTACK_L  = dtack_l_q;
    assign BERR_L   = berr_l_q;
    assign Region_O = region_q;

    assign start = !AS_L && (!UDS_L || !LDS_L);

    always_comb begin
        region_sel = REG_NONE;
        if (OnChipRomSelect_H) begin
            region_sel = REG_ROM;
        end else if (OnChipRamSelect_H) begin
            region_sel = REG_RAM;
        end else if (IOSelect_H) begin
            region_sel = REG_IO;
        end else if (DramSelect_H) begin
            region_sel = REG_DRAM;
        end else if (CanBusSelect_H) begin
            region_sel = REG_CAN;
        end
    end

    // External and unmapped regions count up from zero towards TIMEOUT.
    always_comb begin
        load_val = '0;
        case (region_sel)
            REG_ROM: load_val = ROM_LD;
            REG_RAM: load_val = RAM_LD;
            REG_IO:  load_val = IO_LD;
            default: load_val = '0;
        endcase
    end

    assign ext_ack = ((region_q == REG_DRAM) && !DramDtack_L)
                  || ((region_q == REG_CAN) && !CanDtack_L);

    always_comb begin
        state_d   = state_q;
        region_d  = region_q;
        dtack_l_d = dtack_l_q;
        berr_l_d  = berr_l_q;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_up    = 1'b1;
        unique case (state_q)
            IDLE: begin
                dtack_l_d = 1'b1;
                berr_l_d  = 1'b1;
                if (start) begin
                    state_d  = WAIT;
                    region_d = region_sel;
                    cnt_load = 1'b1;
                end
            end
            WAIT: begin
                if (AS_L) begin
                    state_d  = IDLE;
                    region_d = REG_NONE;
                end else if (region_is_internal(region_q)) begin
                    cnt_up = 1'b0;
                    if (cnt_zero) begin
                        state_d   = ACK;
                        dtack_l_d = 1'b0;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end else if (ext_ack) begin
                    // An ack on the timeout edge still wins.
                    state_d   = ACK;
                    dtack_l_d = 1'b0;
                end else if (cnt_term) begin
                    state_d  = BERR;
                    berr_l_d = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ACK, BERR: begin
                if (AS_L) begin
                    state_d   = IDLE;
                    region_d  = REG_NONE;
                    dtack_l_d = 1'b1;
                    berr_l_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q   <= IDLE;
            region_q  <= REG_NONE;
            dtack_l_q <= 1'b1;
            berr_l_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            region_q  <= region_d;
            dtack_l_q <= dtack_l_d;
            berr_l_q  <= berr_l_d;
        end
    end

    wait_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk      (Clock),
        .rst_n    (Reset_L),
        .load     (cnt_load),
        .load_val (load_val),
        .en       (cnt_en),
        .up       (cnt_up),
        .zero     (cnt_zero),
        .term     (cnt_term)
    );

endmodule

// File: tb/tb_bus_dtack_generator.sv
// Scoreboard bench for bus_dtack_generator: random bus cycles against a
// timing model derived from region wait counts and the timeout rule.
module tb_bus_dtack_generator;

    localparam int ROM_W   = 0;
    localparam int RAM_W   = 1;
    localparam int IO_W    = 3;
    localparam int TMO     = 255;
    localparam int K_DTACK = 1;
    localparam int K_BERR  = 2;

    logic       Clock = 1'b0;
    logic       Reset_L = 1'b0;
    logic       AS_L = 1'b1, UDS_L = 1'b1, LDS_L = 1'b1;
    logic       OnChipRomSelect_H = 1'b0, OnChipRamSelect_H = 1'b0;
    logic       IOSelect_H = 1'b0, DramSelect_H = 1'b0, CanBusSelect_H = 1'b0;
    logic       DramDtack_L = 1'b1, CanDtack_L = 1'b1;
    logic       DTACK_L, BERR_L;
    logic [2:0] Region_O;

    bus_dtack_generator #(
        .ROM_WAIT (ROM_W),
        .RAM_WAIT (RAM_W),
        .IO_WAIT  (IO_W),
        .TIMEOUT  (TMO),
        .CNT_W    (8)
    ) dut (
        .Clock             (Clock),
        .Reset_L           (Reset_L),
        .AS_L              (AS_L),
        .UDS_L             (UDS_L),
        .LDS_L             (LDS_L),
        .OnChipRomSelect_H (OnChipRomSelect_H),
        .OnChipRamSelect_H (OnChipRamSelect_H),
        .IOSelect_H        (IOSelect_H),
        .DramSelect_H      (DramSelect_H),
        .CanBusSelect_H    (CanBusSelect_H),
        .DramDtack_L       (DramDtack_L),
        .CanDtack_L        (CanDtack_L),
        .DTACK_L           (DTACK_L),
        .BERR_L            (BERR_L),
        .Region_O          (Region_O)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc++;

    typedef struct {
        int         kind;
        int         at_edge;
        logic [2:0] region;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   done = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Reference: region by select priority, response kind and the number
    // of edges from the start edge to the response edge.
    function automatic void model(input logic [4:0] sel, input int d,
                                  output logic [2:0] r, output int kind,
                                  output int lat);
        kind = K_DTACK;
        if (sel[0]) begin
            r = 3'd1; lat = 1 + ROM_W;
        end else if (sel[1]) begin
            r = 3'd2; lat = 1 + RAM_W;
        end else if (sel[2]) begin
            r = 3'd3; lat = 1 + IO_W;
        end else begin
            r = sel[3] ? 3'd4 : (sel[4] ? 3'd5 : 3'd0);
            if (r != 3'd0 && d <= TMO + 1) begin
                lat = d;
            end else begin
                kind = K_BERR; lat = TMO + 1;
            end
        end
    endfunction

    // Monitor: every falling DTACK_L/BERR_L is matched to the oldest
    // outstanding expectation.
    initial begin
        logic pdt, pbe;
        exp_t e;
        pdt = 1'b1;
        pbe = 1'b1;
        while (!done) begin
            @(negedge Clock);
            if (!DTACK_L && !BERR_L)
                check("both_low", 1, 0);
            if ((pdt && !DTACK_L) || (pbe && !BERR_L)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", cyc, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind", DTACK_L ? K_BERR : K_DTACK, e.kind);
                    check("resp_edge", cyc, e.at_edge);
                    check("resp_region", Region_O, e.region);
                end
            end
            pdt = DTACK_L;
            pbe = BERR_L;
        end
    end

    task automatic set_sel(input logic [4:0] s);
        {CanBusSelect_H, DramSelect_H, IOSelect_H,
         OnChipRamSelect_H, OnChipRomSelect_H} = s;
    endtask

    // sel: {can,dram,io,ram,rom}; ds: {UDS_L,LDS_L}; d: edges to ext ack;
    // abort_h>0 raises AS_L at start+abort_h if before the response.
    task automatic run_txn(input logic [4:0] sel, input logic [1:0] ds,
                           input int d, input int abort_h, input int extra);
        logic [2:0] r;
        int kind, lat, st, endk;
        exp_t e;
        model(sel, d, r, kind, lat);
        @(negedge Clock);
        set_sel(sel);
        AS_L = 1'b0;
        {UDS_L, LDS_L} = ds;
        st = cyc + 1;
        if (abort_h > 0 && abort_h < lat) begin
            endk = abort_h;
        end else begin
            endk = lat + extra;
            e.kind = kind;
            e.at_edge = st + lat;
            e.region = r;
            exp_q.push_back(e);
        end
        for (int k = 1; k <= endk; k++) begin
            @(negedge Clock);
            set_sel(5'($urandom));
            DramDtack_L = (r == 3'd4) ? !(k >= d) : 1'($urandom);
            CanDtack_L  = (r == 3'd5) ? !(k >= d) : 1'($urandom);
            AS_L = (k == endk);
        end
        @(negedge Clock);
        check("end_dtack", DTACK_L, 1);
        check("end_berr", BERR_L, 1);
        check("end_region", Region_O, 0);
        DramDtack_L = 1'b1;
        CanDtack_L = 1'b1;
        UDS_L = 1'b1;
        LDS_L = 1'b1;
        set_sel(5'd0);
    endtask

    initial begin
        exp_t e;
        int st, lat, kind, hh;
        logic [2:0] r;
        logic [4:0] s;
        logic [1:0] ds;

        repeat (3) @(negedge Clock);
        check("rst_dtack", DTACK_L, 1);
        check("rst_berr", BERR_L, 1);
        check("rst_region", Region_O, 0);
        Reset_L = 1'b1;
        repeat (2) @(negedge Clock);

        run_txn(5'b00001, 2'b10, 1, 0, 3);
        run_txn(5'b00100, 2'b01, 1, 0, 2);
        run_txn(5'b01000, 2'b00, 7, 0, 1);
        run_txn(5'b01000, 2'b10, 1000, 0, 2);
        run_txn(5'b00000, 2'b10, 1, 0, 1);
        run_txn(5'b00011, 2'b10, 1, 0, 1);
        run_txn(5'b00100, 2'b10, 1, 2, 0);
        run_txn(5'b10000, 2'b01, TMO + 1, 0, 1);
        run_txn(5'b10000, 2'b01, 1, 0, 1);

        // Strobes high with AS_L low must not start a cycle.
        @(negedge Clock);
        AS_L = 1'b0;
        set_sel(5'b00001);
        repeat (3) @(negedge Clock);
        check("no_start_dtack", DTACK_L, 1);
        check("no_start_region", Region_O, 0);
        run_txn(5'b00010, 2'b10, 1, 0, 1);

        // Asynchronous reset while acknowledging.
        @(negedge Clock);
        set_sel(5'b00001);
        AS_L = 1'b0;
        LDS_L = 1'b0;
        st = cyc + 1;
        e.kind = K_DTACK;
        e.at_edge = st + 1;
        e.region = 3'd1;
        exp_q.push_back(e);
        repeat (2) @(negedge Clock);
        #2 Reset_L = 1'b0;
        #1;
        check("arst_dtack", DTACK_L, 1);
        check("arst_berr", BERR_L, 1);
        check("arst_region", Region_O, 0);
        AS_L = 1'b1;
        LDS_L = 1'b1;
        set_sel(5'd0);
        @(negedge Clock);
        Reset_L = 1'b1;
        run_txn(5'b00001, 2'b01, 1, 0, 1);

        for (int i = 0; i < 40; i++) begin
            s = 5'($urandom);
            if ($urandom_range(0, 7) == 0) s = 5'd0;
            ds = ($urandom_range(0, 2) == 0) ? 2'b00 :
                 ($urandom_range(0, 1) == 0 ? 2'b01 : 2'b10);
            hh = 0;
            model(s, 1, r, kind, lat);
            if (r == 3'd4 || r == 3'd5) begin
                lat = ($urandom_range(0, 9) == 0) ? 300 :
                      $urandom_range(1, 12);
            end else begin
                if (r == 3'd0 && $urandom_range(0, 1) == 0) s = 5'b00100;
                lat = 1;
            end
            model(s, lat, r, kind, st);
            if ($urandom_range(0, 4) == 0 && st >= 2)
                hh = $urandom_range(1, st - 1);
            run_txn(s, ds, lat, hh, $urandom_range(1, 4));
        end

        repeat (5) @(negedge Clock);
        check("queue_empty", exp_q.size(), 0);
        done = 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
